// File: rtl/write_buffer_if.sv
// write_buffer_if: store push channel between the data cache and the write buffer.
//   write   push request (cache -> buffer)
//   length  store size in bytes (cache -> buffer)
//   addr    byte address of the store (cache -> buffer)
//   data    right-aligned store data (cache -> buffer)
//   busy    buffer full, cache must hold off (buffer -> cache)
interface write_buffer_if;
    logic        write;
    logic [2:0]  length;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;

    modport master (output write, output length, output addr, output data, input busy);
    modport slave  (input write, input length, input addr, input data, output busy);
endinterface

// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between the data cache and the byte-wide RAM arbiter.
// Entries drain in order, one byte per granted cycle; IO-region entries (addr[17])
// stall while io_full is high. A word-granular query port reports pending stores.
//   clock, reset   clock and synchronous active-high reset
//   cache          push channel (write/length/addr/data in, busy out)
//   empty          no pending entries
//   query_addr     address checked against pending entries
//   query_hit      some pending entry covers query_addr[31:2]
//   mem_req        byte write request to the arbiter
//   mem_addr       byte address of the current byte
//   mem_data       current byte
//   mem_grant      arbiter accepts the current byte
//   io_full        IO sink cannot accept writes
module write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    write_buffer_if.slave        cache,
    output logic                 empty,
    input  logic [31:0]          query_addr,
    output logic                 query_hit,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    output logic [7:0]           mem_data,
    input  logic                 mem_grant,
    input  logic                 io_full
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]  length;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    state_t           state_next;
    entry_t           fifo_q [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [2:0]       byte_cnt;
    logic             push;
    logic             retire;
    logic             advance;
    logic             last_byte;
    logic [31:0]      shifted;

    // Flags come from registers only; push has no path to busy.
    assign cache.busy = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign push       = cache.write && !cache.busy;
    assign head       = fifo_q[rd_ptr];

    // Shift amounts of 32 or more (lengths 5..7) yield a zero byte.
    assign shifted    = head.data >> {byte_cnt, 3'b000};
    assign last_byte  = ({1'b0, byte_cnt} + 4'd1) >= {1'b0, head.length};
    assign count_next = count + CNT_W'(push) - CNT_W'(retire);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and drain outputs; SEND tracks the registered occupancy.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        retire     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (count_next != '0) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                mem_req  = (head.length != 3'd0) && !(head.addr[17] && io_full);
                mem_addr = head.addr + 32'(byte_cnt);
                mem_data = shifted[7:0];
                if (head.length == 3'd0) begin
                    retire = 1'b1;
                end else if (mem_req && mem_grant) begin
                    retire  = last_byte;
                    advance = !last_byte;
                end
                if (count_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers, occupancy and byte index.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            byte_cnt <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                byte_cnt <= '0;
            end else if (advance) begin
                byte_cnt <= byte_cnt + 3'd1;
            end
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{length: cache.length, addr: cache.addr, data: cache.data};
        end
    end

    // Hazard query over entries within count of the head (head included until it retires).
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel       = '0;
        query_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(rel) < count) && (fifo_q[i].addr[31:2] == query_addr[31:2])) begin
                query_hit = 1'b1;
            end
        end
    end

endmodule
